// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, op_class encodings and
// class-level helpers used by the decoder and immediate generator.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_AW       = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'h0,
    CLS_LUI     = 4'h1,
    CLS_AUIPC   = 4'h2,
    CLS_JAL     = 4'h3,
    CLS_JALR    = 4'h4,
    CLS_BRANCH  = 4'h5,
    CLS_LOAD    = 4'h6,
    CLS_STORE   = 4'h7,
    CLS_OP_IMM  = 4'h8,
    CLS_OP      = 4'h9,
    CLS_SYSTEM  = 4'hA
  } op_class_t;

  function automatic op_class_t decode_class(input logic [31:0] instr);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    if (instr[1:0] != 2'b11) begin
      cls = CLS_ILLEGAL;
    end else begin
      case (instr[6:0])
        OPC_LUI:    cls = CLS_LUI;
        OPC_AUIPC:  cls = CLS_AUIPC;
        OPC_JAL:    cls = CLS_JAL;
        OPC_JALR:   cls = CLS_JALR;
        OPC_BRANCH: cls = CLS_BRANCH;
        OPC_LOAD:   cls = CLS_LOAD;
        OPC_STORE:  cls = CLS_STORE;
        OPC_OP_IMM: cls = CLS_OP_IMM;
        OPC_OP:     cls = CLS_OP;
        OPC_SYSTEM: cls = CLS_SYSTEM;
        default:    cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

  function automatic logic uses_rs1(input op_class_t cls);
    logic used;
    case (cls)
      CLS_LUI, CLS_AUIPC, CLS_JAL: used = 1'b0;
      default:                     used = 1'b1;
    endcase
    return used;
  endfunction

  function automatic logic uses_rs2(input op_class_t cls);
    logic used;
    case (cls)
      CLS_BRANCH, CLS_STORE, CLS_OP: used = 1'b1;
      default:                       used = 1'b0;
    endcase
    return used;
  endfunction

  function automatic logic writes_rd(input op_class_t cls);
    logic wr;
    case (cls)
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
      CLS_LOAD, CLS_OP_IMM, CLS_OP: wr = 1'b1;
      default:                      wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction for RV32I formats, sign-extended to XLEN.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     i_instr,
  input  op_class_t       i_op_class,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;
  logic               w_unused_opcode;

  // Opcode bits are consumed by the class decode, not by any immediate format.
  assign w_unused_opcode = ^i_instr[6:0];

  // Select the immediate format for the decoded class.
  always_comb begin
    w_imm32 = 32'sd0;
    case (i_op_class)
      CLS_LUI, CLS_AUIPC:
        w_imm32 = {i_instr[31:12], 12'h000};
      CLS_JAL:
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                   i_instr[30:21], 1'b0};
      CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_SYSTEM:
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      CLS_STORE:
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      CLS_BRANCH:
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                   i_instr[11:8], 1'b0};
      default:
        w_imm32 = 32'sd0;
    endcase
  end

  assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/inst_decode.sv
// RV32I decode stage: fetch/execute handshake, registered decode fields and
// a one-entry load-use hazard tracker that inserts a single bubble.
module inst_decode
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  output logic              rf_rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] rd_addr,
  output logic              rd_we,
  output logic [XLEN-1:0]   imm,
  output logic [3:0]        op_class,
  output logic [2:0]        funct3,
  output logic              funct7b5,
  output logic              illegal
);

  op_class_t         w_class;
  logic [REG_AW-1:0] w_rd_field;
  logic [REG_AW-1:0] w_rd_addr;
  logic              w_rd_we;
  logic              w_illegal;
  logic              w_stall;
  logic              w_accept;
  logic [XLEN-1:0]   w_imm;

  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_pc;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_rd_we;
  logic [XLEN-1:0]   r_imm;
  op_class_t         r_op_class;
  logic [2:0]        r_funct3;
  logic              r_funct7b5;
  logic              r_illegal;
  logic              r_pend_vld;
  logic [REG_AW-1:0] r_pend_rd;

  assign rs1_addr   = in_instr[19:15];
  assign rs2_addr   = in_instr[24:20];
  assign w_rd_field = in_instr[11:7];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr    (in_instr),
    .i_op_class (w_class),
    .o_imm      (w_imm)
  );

  // Decode the class, destination fields and load-use hazard against the pending load.
  always_comb begin
    w_class   = decode_class(in_instr);
    w_rd_addr = w_rd_field;
    if ((w_class == CLS_BRANCH) || (w_class == CLS_STORE)) begin
      w_rd_addr = '0;
    end else begin
      w_rd_addr = w_rd_field;
    end
    w_rd_we   = writes_rd(w_class) && (w_rd_field != 5'd0);
    w_illegal = (w_class == CLS_ILLEGAL);
    // pend_rd is never x0 while pend_vld is set, so x0 sources never stall.
    w_stall   = r_pend_vld && in_valid &&
                ((uses_rs1(w_class) && (rs1_addr == r_pend_rd)) ||
                 (uses_rs2(w_class) && (rs2_addr == r_pend_rd)));
  end

  assign in_ready = !rst && !flush && !w_stall && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign rf_rd_en = w_accept;

  // Output register stage: loads on accept, holds under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_rd_addr   <= '0;
      r_rd_we     <= 1'b0;
      r_imm       <= '0;
      r_op_class  <= CLS_ILLEGAL;
      r_funct3    <= 3'd0;
      r_funct7b5  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (out_ready || !r_out_valid) begin
        r_out_valid <= w_accept;
      end
      if (w_accept) begin
        r_out_pc   <= in_pc;
        r_rd_addr  <= w_rd_addr;
        r_rd_we    <= w_rd_we;
        r_imm      <= w_imm;
        r_op_class <= w_class;
        r_funct3   <= in_instr[14:12];
        r_funct7b5 <= in_instr[30];
        r_illegal  <= w_illegal;
      end
    end
  end

  // Pending-load tracker: armed by an accepted load, retired once it moves on.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_pend_vld <= 1'b0;
      r_pend_rd  <= '0;
    end else if (w_accept) begin
      r_pend_vld <= (w_class == CLS_LOAD) && (w_rd_field != 5'd0);
      r_pend_rd  <= w_rd_field;
    end else if (out_ready) begin
      r_pend_vld <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign rd_addr   = r_rd_addr;
  assign rd_we     = r_rd_we;
  assign imm       = r_imm;
  assign op_class  = r_op_class;
  assign funct3    = r_funct3;
  assign funct7b5  = r_funct7b5;
  assign illegal   = r_illegal;

endmodule
